// File: rtl/dmem_ctrl_seq_pkg.sv
// Shared command and state encodings for the BeeF data-memory controller.
package dmem_ctrl_seq_pkg;

  typedef enum logic [2:0] {
    CMD_NOP     = 3'd0,
    CMD_RD      = 3'd1,
    CMD_WR_REG  = 3'd2,
    CMD_WR_ALU  = 3'd3,
    CMD_INC     = 3'd4,
    CMD_DEC     = 3'd5,
    CMD_PUSH_PC = 3'd6
  } mem_cmd_t;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RMW_RD = 2'd1,
    S_RMW_WR = 2'd2,
    S_PUSH   = 2'd3
  } dmem_state_t;

endpackage

// File: rtl/dmem_ctrl_seq_sp_ram.sv
// Single-port synchronous RAM with registered read. A write returns the
// written word on the read port the next cycle (write-first).
module dmem_sp_ram #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [0:(2**ADDR_W)-1];

  // Storage write and registered read; contents are never cleared.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
      rdata     <= wdata;
    end else begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/dmem_ctrl_seq.sv
// Sequenced data-memory controller: owns the data RAM and runs single-cycle
// reads/writes, INC/DEC read-modify-write, and multi-word PC pushes.
module dmem_ctrl_seq
  import dmem_ctrl_seq_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 8,
  parameter int PC_W     = 17,
  parameter int PC_BYTES = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  mem_cmd_t          cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] reg_value,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [PC_W-1:0]   pc,
  input  logic              override,
  input  logic              force_write,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              busy
);

  localparam int PCX_W = PC_BYTES * DATA_W;
  localparam int CNT_W = (PC_BYTES > 1) ? $clog2(PC_BYTES) : 1;

  dmem_state_t state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              dec_q, dec_d;
  logic [PC_BYTES-1:0][DATA_W-1:0] pc_q, pc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rd_pend_q, rd_pend_d;
  logic [DATA_W-1:0] hold_q, hold_d;

  logic [PC_BYTES-1:0][DATA_W-1:0] pc_words;
  logic              accept;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic [DATA_W-1:0] rmw_val;

  // PC zero-extended to a whole number of words, word 0 least significant.
  assign pc_words  = PCX_W'(pc);
  assign cmd_ready = (state_q == S_IDLE) && !reset;
  assign accept    = cmd_valid && cmd_ready;
  assign busy      = (state_q != S_IDLE);
  assign rmw_val   = dec_q ? (ram_rdata - DATA_W'(1)) : (ram_rdata + DATA_W'(1));

  // Read data: fresh RAM word after a read, the modified word during the
  // RMW write cycle, otherwise the last value presented.
  assign rd_data  = rd_pend_q ? ram_rdata :
                    (state_q == S_RMW_WR) ? rmw_val : hold_q;
  assign rd_valid = !reset && (rd_pend_q || (state_q == S_RMW_WR));
  assign hold_d   = rd_valid ? rd_data : hold_q;

  // Next-state, command latching and RAM port mux.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    dec_d     = dec_q;
    pc_d      = pc_q;
    cnt_d     = cnt_q;
    rd_pend_d = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = cmd_addr;
    ram_wdata = reg_value;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (override) begin
            ram_we = force_write;
          end else begin
            case (cmd_op)
              CMD_RD:     rd_pend_d = 1'b1;
              CMD_WR_REG: ram_we = 1'b1;
              CMD_WR_ALU: begin
                ram_we    = 1'b1;
                ram_wdata = alu_result;
              end
              CMD_INC, CMD_DEC: begin
                addr_d  = cmd_addr;
                dec_d   = (cmd_op == CMD_DEC);
                state_d = S_RMW_RD;
              end
              CMD_PUSH_PC: begin
                // Word 0 goes out in the acceptance cycle itself.
                ram_we    = 1'b1;
                ram_wdata = pc_words[0];
                addr_d    = cmd_addr;
                pc_d      = pc_words;
                cnt_d     = CNT_W'(1);
                state_d   = (PC_BYTES > 1) ? S_PUSH : S_IDLE;
              end
              default: ;
            endcase
          end
        end
      end
      S_RMW_RD: begin
        ram_addr = addr_q;
        state_d  = S_RMW_WR;
      end
      S_RMW_WR: begin
        ram_addr  = addr_q;
        ram_we    = 1'b1;
        ram_wdata = rmw_val;
        state_d   = S_IDLE;
      end
      S_PUSH: begin
        // Address arithmetic wraps naturally at ADDR_W bits.
        ram_addr  = addr_q + ADDR_W'(cnt_q);
        ram_we    = 1'b1;
        ram_wdata = pc_q[cnt_q];
        if (cnt_q == CNT_W'(PC_BYTES - 1)) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    // A reset cycle must never disturb memory.
    if (reset) begin
      ram_we = 1'b0;
    end
  end

  // State and latch registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      rd_pend_q <= 1'b0;
      hold_q    <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      rd_pend_q <= rd_pend_d;
      hold_q    <= hold_d;
      cnt_q     <= cnt_d;
    end
    addr_q <= addr_d;
    dec_q  <= dec_d;
    pc_q   <= pc_d;
  end

  dmem_sp_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_dmem_ctrl_seq.sv
// Randomized bench for dmem_ctrl_seq against a cycle-indexed behavioural model.
module tb_dmem_ctrl_seq;
  import dmem_ctrl_seq_pkg::*;

  localparam int DEPTH = 8192;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, cmd_valid, cmd_ready, override, force_write;
  mem_cmd_t   cmd_op;
  logic [7:0] cmd_addr, reg_value, alu_result, rd_data;
  logic [16:0] pc;
  logic       rd_valid, busy;

  dmem_ctrl_seq #(.DATA_W(8), .ADDR_W(8), .PC_W(17), .PC_BYTES(3)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .reg_value(reg_value),
    .alu_result(alu_result), .pc(pc), .override(override),
    .force_write(force_write), .rd_data(rd_data), .rd_valid(rd_valid),
    .busy(busy)
  );

  // Interval index: number of rising edges seen so far.
  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  // Expected outputs per interval, plus the model memory image.
  logic       exp_ready [DEPTH];
  logic       exp_busy  [DEPTH];
  logic       exp_rv    [DEPTH];
  logic [7:0] exp_rd    [DEPTH];
  logic [7:0] mdl       [256];

  int vectors = 0;
  int miscompares = 0;
  logic chk_en = 1'b0;
  logic [7:0] cap_rd = 8'h00;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, got, exp);
    end
  endtask

  // Per-cycle compare of every output against the model timeline.
  always @(negedge clk) begin
    if (chk_en && cyc < DEPTH) begin
      chk("cmd_ready", 32'(cmd_ready), 32'(exp_ready[cyc]));
      chk("busy", 32'(busy), 32'(exp_busy[cyc]));
      chk("rd_valid", 32'(rd_valid), 32'(exp_rv[cyc]));
      if (exp_rv[cyc]) chk("rd_data", 32'(rd_data), 32'(exp_rd[cyc]));
      if (rd_valid) cap_rd = rd_data;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Garbage on the command inputs while the controller is busy.
  task automatic noise();
    cmd_valid   = 1'($urandom);
    cmd_op      = mem_cmd_t'($urandom_range(0, 6));
    cmd_addr    = 8'($urandom);
    reg_value   = 8'($urandom);
    alu_result  = 8'($urandom);
    pc          = 17'($urandom);
    override    = 1'($urandom);
    force_write = 1'($urandom);
  endtask

  task automatic idle();
    cmd_valid = 1'b0;
    override  = 1'b0;
    step();
  endtask

  // Present one command in the current interval and advance the model.
  task automatic issue(input mem_cmd_t op, input logic [7:0] a, input logic [7:0] rv,
                       input logic [7:0] av, input logic [16:0] p,
                       input logic ov, input logic fw);
    int k;
    int dur;
    logic [7:0] nv;
    k = cyc;
    if (k + 4 >= DEPTH) begin
      $display("FAIL cycle_budget at cycle %0d: got %0d expected below %0d", k, k + 4, DEPTH);
      $fatal(1);
    end
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; reg_value = rv;
    alu_result = av; pc = p; override = ov; force_write = fw;
    dur = 1;
    if (ov) begin
      if (fw) mdl[a] = rv;
    end else begin
      case (op)
        CMD_RD: begin exp_rv[k+1] = 1'b1; exp_rd[k+1] = mdl[a]; end
        CMD_WR_REG: mdl[a] = rv;
        CMD_WR_ALU: mdl[a] = av;
        CMD_INC, CMD_DEC: begin
          nv = (op == CMD_INC) ? mdl[a] + 8'd1 : mdl[a] - 8'd1;
          mdl[a] = nv;
          exp_rv[k+2] = 1'b1;
          exp_rd[k+2] = nv;
          dur = 3;
        end
        CMD_PUSH_PC: begin
          for (int i = 0; i < 3; i++) mdl[8'(32'(a) + i)] = 8'(p >> (8 * i));
          dur = 3;
        end
        default: ;
      endcase
    end
    if (dur == 3) begin
      exp_busy[k+1] = 1'b1; exp_busy[k+2] = 1'b1;
      exp_ready[k+1] = 1'b0; exp_ready[k+2] = 1'b0;
    end
    step();
    if (dur == 3) begin
      noise(); step();
      noise(); step();
      cmd_valid = 1'b0;
      override  = 1'b0;
    end
  endtask

  // Literal check of rd_data in the current interval, then move on.
  task automatic lit_now(input string nm, input logic [7:0] e);
    cmd_valid = 1'b0;
    override  = 1'b0;
    @(negedge clk);
    #1;
    chk(nm, 32'(rd_data), 32'(e));
    step();
  endtask

  task automatic lit_cap(input string nm, input logic [7:0] e);
    chk(nm, 32'(cap_rd), 32'(e));
  endtask

  task automatic push_with_reset();
    int k;
    k = cyc;
    cmd_valid = 1'b1; cmd_op = CMD_PUSH_PC; cmd_addr = 8'h80;
    pc = 17'h0ABCD; override = 1'b0;
    mdl[8'h80] = 8'hCD;
    exp_busy[k+1] = 1'b1;
    exp_ready[k+1] = 1'b0;
    step();
    noise();
    reset = 1'b1;
    step();
    reset = 1'b0;
    cmd_valid = 1'b0;
    override = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      exp_ready[i] = 1'b1; exp_busy[i] = 1'b0; exp_rv[i] = 1'b0; exp_rd[i] = 8'h00;
    end
    exp_ready[0] = 1'b0;
    exp_ready[1] = 1'b0;
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = CMD_NOP; cmd_addr = 8'h00;
    reg_value = 8'h00; alu_result = 8'h00; pc = 17'h0; override = 1'b0;
    force_write = 1'b0;
    @(posedge clk);
    chk_en = 1'b1;
    step();
    reset = 1'b0;
    lit_now("rd_data_reset", 8'h00);

    // Fill memory through the override path (cmd_op must be ignored).
    for (int i = 0; i < 256; i++)
      issue(CMD_INC, 8'(i), 8'($urandom), 8'h00, 17'h0, 1'b1, 1'b1);

    issue(CMD_WR_ALU, 8'h10, 8'h00, 8'h5A, 17'h0, 1'b0, 1'b0);
    issue(CMD_RD, 8'h10, 8'h00, 8'h00, 17'h0, 1'b0, 1'b0);
    lit_now("rd_0x10", 8'h5A);

    issue(CMD_WR_REG, 8'h20, 8'hFF, 8'h00, 17'h0, 1'b0, 1'b0);
    issue(CMD_INC, 8'h20, 8'h00, 8'h00, 17'h0, 1'b0, 1'b0);
    lit_cap("inc_wrap", 8'h00);
    issue(CMD_RD, 8'h20, 8'h00, 8'h00, 17'h0, 1'b0, 1'b0);
    lit_now("rd_after_inc", 8'h00);
    issue(CMD_DEC, 8'h20, 8'h00, 8'h00, 17'h0, 1'b0, 1'b0);
    lit_cap("dec_wrap", 8'hFF);

    issue(CMD_PUSH_PC, 8'hFE, 8'h00, 8'h00, 17'h12345, 1'b0, 1'b0);
    issue(CMD_RD, 8'hFE, 8'h00, 8'h00, 17'h0, 1'b0, 1'b0);
    lit_now("push_b0", 8'h45);
    issue(CMD_RD, 8'hFF, 8'h00, 8'h00, 17'h0, 1'b0, 1'b0);
    lit_now("push_b1", 8'h23);
    issue(CMD_RD, 8'h00, 8'h00, 8'h00, 17'h0, 1'b0, 1'b0);
    lit_now("push_b2_wrap", 8'h01);

    issue(CMD_INC, 8'h40, 8'h33, 8'h00, 17'h0, 1'b1, 1'b1);
    issue(CMD_RD, 8'h40, 8'h00, 8'h00, 17'h0, 1'b0, 1'b0);
    lit_now("override_write", 8'h33);
    issue(CMD_WR_REG, 8'h40, 8'h77, 8'h00, 17'h0, 1'b1, 1'b0);
    issue(CMD_RD, 8'h40, 8'h00, 8'h00, 17'h0, 1'b0, 1'b0);
    lit_now("override_nowrite", 8'h33);

    issue(CMD_WR_REG, 8'h81, 8'h5C, 8'h00, 17'h0, 1'b0, 1'b0);
    issue(CMD_WR_REG, 8'h82, 8'hC3, 8'h00, 17'h0, 1'b0, 1'b0);
    push_with_reset();
    lit_now("rd_data_after_reset", 8'h00);
    issue(CMD_RD, 8'h80, 8'h00, 8'h00, 17'h0, 1'b0, 1'b0);
    lit_now("reset_push_b0", 8'hCD);
    issue(CMD_RD, 8'h81, 8'h00, 8'h00, 17'h0, 1'b0, 1'b0);
    lit_now("reset_push_b1_kept", 8'h5C);
    issue(CMD_RD, 8'h82, 8'h00, 8'h00, 17'h0, 1'b0, 1'b0);
    lit_now("reset_push_b2_kept", 8'hC3);

    issue(CMD_RD, 8'h01, 8'h00, 8'h00, 17'h0, 1'b0, 1'b0);
    issue(CMD_RD, 8'h02, 8'h00, 8'h00, 17'h0, 1'b0, 1'b0);
    issue(CMD_RD, 8'h03, 8'h00, 8'h00, 17'h0, 1'b0, 1'b0);
    idle();

    repeat (500) begin
      logic [7:0] a;
      if ($urandom_range(0, 3) == 0) idle();
      a = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(253, 255)) : 8'($urandom);
      issue(mem_cmd_t'($urandom_range(0, 6)), a, 8'($urandom), 8'($urandom),
            17'($urandom), ($urandom_range(0, 7) == 0), 1'($urandom));
    end
    idle();

    for (int i = 0; i < 256; i++)
      issue(CMD_RD, 8'(i), 8'h00, 8'h00, 17'h0, 1'b0, 1'b0);
    idle();
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
